multi_timer: RTL
================

// Module: multi_timer
// PURPOSE
//  Parametrised multi-channel programmable timer; successor of the single-channel bridge timer.
//  NCH independent down-counters, each with one-shot/periodic mode and a power-of-two prescaler.
//  Each channel has a sticky write-1-to-clear pending flag and a masked interrupt.
//  Sits on the CPU peripheral bridge. Per-channel interrupts are ORed onto one IRQ line for CP0.
// PARAMETERS
//  CH_BITS  1   log2 of channel count; NCH = 2**CH_BITS
//  CW       32  counter/PRESET width (1..32); reads zero-extend to 32 bits
//  PS_W     15  prescaler counter width; prescale select max = 15
// PORTS
//  clk      in   1          system clock, rising edge
//  reset_n  in   1          asynchronous, active-low reset
//  Addr     in   CH_BITS+2  word address [CH_BITS+3:2]; hi bits = channel, lo 2 bits = register
//  WE       in   1          write enable, single cycle
//  DataI    in   32         write data
//  DataO    out  32         read data, combinational from Addr and current register state
//  irq_vec  out  NCH        per-channel interrupt = pending & CTRL.IM
//  IRQ      out  1          OR of irq_vec
// BEHAVIOUR
//  Register map per channel (reg = Addr[3:2]):
//   - 0 CTRL: [0] EN, [2:1] MODE (00 one-shot, 01 periodic, 1x = one-shot), [3] IM, [7:4] PS; others read 0.
//   - 1 PRESET: RW, CW bits.
//   - 2 COUNT: read-only; writes ignored.
//   - 3 STATUS: [0] pending. Write 1 clears it; write 0 has no effect.
//  Reset (async, reset_n=0): all CTRL/PRESET/COUNT/prescaler/pending = 0, state IDLE, irq_vec = 0, IRQ = 0.
//  Per-channel FSM:
//   - IDLE: COUNT holds.
//   - LOAD (1 cycle): COUNT <= PRESET, prescaler <= 0.
//       PRESET != 0 -> CNTING.
//       PRESET == 0 -> DONE, and pending <= 1.
//   - CNTING: tick when the prescaler reaches 2**PS - 1; prescaler then wraps to 0. PS = 0 gives a tick every cycle.
//       On a tick, COUNT <= COUNT - 1.
//       On a tick with COUNT == 1:
//         one-shot: COUNT <= 0, pending <= 1, -> DONE.
//         periodic: pending <= 1, COUNT <= PRESET (no dead cycle), stay in CNTING.
//           If PRESET == 0 at that point, COUNT <= 0 -> DONE.
//   - DONE: COUNT holds 0 until CTRL is rewritten.
//  Write CTRL (any state):
//   - EN = 1 -> LOAD next cycle, restarting the channel.
//   - EN = 0 -> IDLE, COUNT frozen.
//   - Pending is not touched.
//  Write PRESET while in LOAD: the written DataI is loaded that same edge (forwarded).
//  Write PRESET while in CNTING: takes effect at the next reload/restart only.
//  Simultaneous pending set and STATUS W1C on the same edge: set wins, pending stays 1.
//  irq_vec/IRQ are functions of registers only; they assert the cycle after the terminal tick edge.
//  Clearing IM masks the interrupt but keeps pending. Setting IM with pending = 1 raises IRQ immediately.
//  Counter arithmetic is modulo 2**CW. COUNT never underflows in CNTING because of the ==1 terminal test.
//  Channels are fully independent. A write touches only the addressed channel.
//  Read latency: 0 cycles, i.e. DataO reflects pre-edge state.
// TESTING
//  1. Reset mid-count: ch0 PRESET = 5, CTRL = 0x9 (EN, IM); drop reset_n at COUNT = 2.
//     -> COUNT = 0, CTRL = 0, IRQ = 0 immediately, before the next clk edge.
//  2. One-shot, PS = 0: PRESET = 3, CTRL = 0x9.
//     -> COUNT reads 3, 2, 1, 0 on successive cycles after LOAD. irq_vec[0] = 1 the cycle COUNT = 0.
//     -> Write STATUS = 1 -> IRQ = 0; COUNT stays 0.
//  3. Periodic + prescale: PRESET = 2, CTRL = 0x1B (EN, periodic, IM, PS = 1).
//     -> COUNT decrements every 2 cycles. Pending is set every 4 cycles; COUNT sequence 2, 2, 1, 1, 2, ...
//  4. PRESET = 0 with EN: LOAD -> DONE. Pending = 1 two cycles after the CTRL write; IRQ only if IM = 1.
//  5. Same-edge conflict: W1C STATUS on the exact terminal-tick cycle -> pending = 1 afterwards.
//     PRESET write during LOAD of 7 -> COUNT = 7.
//  6. Two channels: ch0 PRESET = 4, ch1 PRESET = 2, both EN|IM.
//     -> irq_vec = 2'b10 first, then 2'b11. Clearing ch1 leaves IRQ = 1. Writes to ch1 never change ch0 registers.

Source files
------------

// File: rtl/multi_timer.sv
// Multi-channel programmable down-counter timer for the CPU peripheral bridge.
// Each channel has a prescaler, one-shot/periodic reload, a sticky pending flag and a masked interrupt.
module multi_timer #(
  parameter int CH_BITS = 1,
  parameter int CW      = 32,
  parameter int PS_W    = 15
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [CH_BITS+1:0]      Addr,
  input  logic                    WE,
  input  logic [31:0]             DataI,
  output logic [31:0]             DataO,
  output logic [(2**CH_BITS)-1:0] irq_vec,
  output logic                    IRQ
);

  localparam int NCH = 2 ** CH_BITS;

  typedef enum logic [1:0] {IDLE, LOAD, CNTING, DONE} state_e;

  state_e            state_q  [NCH];
  state_e            state_d  [NCH];
  logic [7:0]        ctrl_q   [NCH];
  logic [7:0]        ctrl_d   [NCH];
  logic [CW-1:0]     preset_q [NCH];
  logic [CW-1:0]     preset_d [NCH];
  logic [CW-1:0]     count_q  [NCH];
  logic [CW-1:0]     count_d  [NCH];
  logic [PS_W-1:0]   presc_q  [NCH];
  logic [PS_W-1:0]   presc_d  [NCH];
  logic              pend_q   [NCH];
  logic              pend_d   [NCH];

  logic [CH_BITS-1:0] acc_ch;
  logic [1:0]         acc_reg;
  logic               sel      [NCH];
  logic               set_pend [NCH];
  logic [CW-1:0]      load_val [NCH];
  logic [PS_W-1:0]    limit    [NCH];

  assign acc_ch  = Addr[CH_BITS+1:2];
  assign acc_reg = Addr[1:0];

  always_comb begin
    for (int ch = 0; ch < NCH; ch++) begin
      state_d[ch]  = state_q[ch];
      ctrl_d[ch]   = ctrl_q[ch];
      preset_d[ch] = preset_q[ch];
      count_d[ch]  = count_q[ch];
      presc_d[ch]  = presc_q[ch];
      set_pend[ch] = 1'b0;
      sel[ch]      = WE && (acc_ch == CH_BITS'(ch));
      // A PRESET write landing in LOAD is forwarded straight into COUNT.
      load_val[ch] = (sel[ch] && acc_reg == 2'd1) ? DataI[CW-1:0] : preset_q[ch];
      limit[ch]    = PS_W'((32'd1 << ctrl_q[ch][7:4]) - 32'd1);

      case (state_q[ch])
        LOAD: begin
          count_d[ch] = load_val[ch];
          presc_d[ch] = '0;
          if (load_val[ch] == '0) begin
            state_d[ch]  = DONE;
            set_pend[ch] = 1'b1;
          end else begin
            state_d[ch] = CNTING;
          end
        end
        CNTING: begin
          if (presc_q[ch] == limit[ch]) begin
            presc_d[ch] = '0;
            if (count_q[ch] == CW'(1)) begin
              set_pend[ch] = 1'b1;
              if (ctrl_q[ch][2:1] == 2'b01 && preset_q[ch] != '0) begin
                count_d[ch] = preset_q[ch];
              end else begin
                count_d[ch] = '0;
                state_d[ch] = DONE;
              end
            end else begin
              count_d[ch] = count_q[ch] - CW'(1);
            end
          end else begin
            presc_d[ch] = presc_q[ch] + PS_W'(1);
          end
        end
        default: ;
      endcase

      // A CTRL write overrides whatever the channel was doing this edge.
      if (sel[ch] && acc_reg == 2'd0) begin
        ctrl_d[ch]   = DataI[7:0];
        state_d[ch]  = DataI[0] ? LOAD : IDLE;
        count_d[ch]  = count_q[ch];
        presc_d[ch]  = presc_q[ch];
        set_pend[ch] = 1'b0;
      end

      if (sel[ch] && acc_reg == 2'd1) begin
        preset_d[ch] = DataI[CW-1:0];
      end

      if (set_pend[ch]) begin
        pend_d[ch] = 1'b1;
      end else if (sel[ch] && acc_reg == 2'd3 && DataI[0]) begin
        pend_d[ch] = 1'b0;
      end else begin
        pend_d[ch] = pend_q[ch];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int ch = 0; ch < NCH; ch++) begin
        state_q[ch]  <= IDLE;
        ctrl_q[ch]   <= '0;
        preset_q[ch] <= '0;
        count_q[ch]  <= '0;
        presc_q[ch]  <= '0;
        pend_q[ch]   <= 1'b0;
      end
    end else begin
      for (int ch = 0; ch < NCH; ch++) begin
        state_q[ch]  <= state_d[ch];
        ctrl_q[ch]   <= ctrl_d[ch];
        preset_q[ch] <= preset_d[ch];
        count_q[ch]  <= count_d[ch];
        presc_q[ch]  <= presc_d[ch];
        pend_q[ch]   <= pend_d[ch];
      end
    end
  end

  always_comb begin
    DataO = '0;
    case (acc_reg)
      2'd0:    DataO = 32'(ctrl_q[acc_ch]);
      2'd1:    DataO = 32'(preset_q[acc_ch]);
      2'd2:    DataO = 32'(count_q[acc_ch]);
      default: DataO = 32'(pend_q[acc_ch]);
    endcase
  end

  always_comb begin
    for (int ch = 0; ch < NCH; ch++) begin
      irq_vec[ch] = pend_q[ch] & ctrl_q[ch][3];
    end
  end

  assign IRQ = |irq_vec;

endmodule
